// File: rtl/ula_seq.sv
// Command sequencer in front of the 8-bit ULA: queues commands, feeds them to the ULA one at a time,
// waits out the ULA latency, and presents each result on a valid/ready port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1. A valid that is
// raised stays high, with its payload stable, until that transfer; ready may change at any time.
module ula_seq #(
  parameter int DEPTH   = 4,
  parameter int ULA_LAT = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_op,
  input  logic [7:0] ula_s,
  input  logic       ula_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_s,
  output logic       res_flag,
  output logic [2:0] res_op,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(ULA_LAT + 1) > 0 ? $clog2(ULA_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_mem_a  [DEPTH];
  logic [7:0]    r_mem_b  [DEPTH];
  logic [2:0]    r_mem_op [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_cnt;

  logic [7:0] r_ula_a;
  logic [7:0] r_ula_b;
  logic [2:0] r_ula_op;
  logic [7:0] r_res_s;
  logic       r_res_flag;
  logic [2:0] r_res_op;
  logic       r_res_valid;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_capture;
  logic w_release;
  logic w_lat_done;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign cmd_ready  = ~w_full & clr;
  assign w_push     = cmd_valid & cmd_ready;
  assign w_pop      = w_load;
  assign w_lat_done = (r_cnt == CW'(ULA_LAT));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_lat_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_release = 1'b1;
          // Back-to-back issue: the next command leaves the queue on the same edge the result is taken.
          if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !w_lat_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Storage needs no reset: the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr]  <= cmd_a;
      r_mem_b[r_wptr]  <= cmd_b;
      r_mem_op[r_wptr] <= cmd_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_ula_a  <= '0;
      r_ula_b  <= '0;
      r_ula_op <= '0;
    end else if (w_load) begin
      r_ula_a  <= r_mem_a[r_rptr];
      r_ula_b  <= r_mem_b[r_rptr];
      r_ula_op <= r_mem_op[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_res_s     <= '0;
      r_res_flag  <= 1'b0;
      r_res_op    <= '0;
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_s     <= ula_s;
      r_res_flag  <= ula_flag;
      r_res_op    <= r_ula_op;
      r_res_valid <= 1'b1;
    end else if (w_release) begin
      r_res_valid <= 1'b0;
    end
  end

  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;
  assign ula_op    = r_ula_op;
  assign res_s     = r_res_s;
  assign res_flag  = r_res_flag;
  assign res_op    = r_res_op;
  assign res_valid = r_res_valid;
  assign busy      = (r_state != S_IDLE) | ~w_empty;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq with a two-register ULA model hanging off the ula_* ports.
module tb_ula_seq;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [2:0] ula_op;
  logic [7:0] ula_s;
  logic       ula_flag;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_s;
  logic       res_flag;
  logic [2:0] res_op;
  logic       busy;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int valid_hi_cycles = 0;

  logic [7:0] got_s[$];
  logic [2:0] got_op[$];
  logic       got_flag[$];
  int         got_cyc[$];

  ula_seq #(.DEPTH(4), .ULA_LAT(2)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_flag(ula_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_flag(res_flag), .res_op(res_op),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ULA model: input register, combinational op, output register on s; flag comes off the input register.
  function automatic logic [8:0] ula_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {(a < b), 7'd0, (a < b)};
      3'd3: r = {(a > b), 7'd0, (a > b)};
      3'd4: r = {1'b0, a & b};
      3'd5: r = {1'b0, a | b};
      3'd6: r = {1'b0, a ^ b};
      default: r = {1'b0, a ~^ b};
    endcase
    return r;
  endfunction

  logic [7:0] m_a, m_b, m_s;
  logic [2:0] m_op;
  logic [8:0] w_m_res;
  assign w_m_res  = ula_fn(m_a, m_b, m_op);
  assign ula_s    = m_s;
  assign ula_flag = w_m_res[8];

  always @(posedge clk) begin
    m_a  <= ula_a;
    m_b  <= ula_b;
    m_op <= ula_op;
    m_s  <= w_m_res[7:0];
  end

  // Result monitor: logs every accepted result with the edge number it was taken on.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (res_valid) valid_hi_cycles <= valid_hi_cycles + 1;
    if (clr && res_valid && res_ready) begin
      got_s.push_back(res_s);
      got_op.push_back(res_op);
      got_flag.push_back(res_flag);
      got_cyc.push_back(cyc + 1);
    end
  end

  task automatic clear_log();
    got_s.delete();
    got_op.delete();
    got_flag.delete();
    got_cyc.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int edge_no);
    bit acc;
    int k;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    k = 0;
    edge_no = -1;
    forever begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        edge_no = cyc;
        break;
      end
      k++;
      if (k > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL push_timeout: cmd_ready stayed low, required 1 within 50 cycles");
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_s.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    ok = (got_s.size() >= n);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = 8'hAA;
    cmd_b = 8'h55;
    cmd_op = 3'd6;
    res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
      n_cmp++;
      if ({ula_a, ula_b, ula_op} !== 19'd0) begin
        n_fail++; $display("FAIL reset_ula: got a=%h b=%h op=%h want 0", ula_a, ula_b, ula_op);
      end
      n_cmp++;
      if ({res_valid, res_s, res_flag, res_op, busy} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_res: got v=%b s=%h f=%b op=%h busy=%b want 0", res_valid, res_s, res_flag, res_op, busy);
      end
    end
    cmd_valid = 1'b0;
    clr = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    n_cmp++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_release_idle: got busy=%b state=%0d want 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_single_and();
    int p;
    res_ready = 1'b1;
    clear_log();
    push(8'hF0, 8'h3C, 3'd4, p);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        n_cmp++;
        if (ula_a !== 8'hF0 || ula_b !== 8'h3C || ula_op !== 3'd4 || dbg_state !== ST_WAIT) begin
          n_fail++;
          $display("FAIL and_load: got a=%h b=%h op=%h st=%0d want f0 3c 4 1", ula_a, ula_b, ula_op, dbg_state);
        end
      end
      if (k < 4) begin
        n_cmp++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL and_early_valid: P+%0d got 1 want 0", k); end
      end else if (k == 4) begin
        n_cmp++;
        if (res_valid !== 1'b1 || res_s !== 8'h30 || res_op !== 3'd4) begin
          n_fail++;
          $display("FAIL and_result: got v=%b s=%h op=%h want 1 30 4", res_valid, res_s, res_op);
        end
      end else begin
        n_cmp++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL and_valid_drop: got 1 want 0"); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_s[4]   = '{8'h46, 8'hAF, 8'hF0, 8'h01};
    logic [2:0] exp_op[4]  = '{3'd0, 3'd5, 3'd6, 3'd0};
    logic       exp_f[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    int p;
    bit ok;
    res_ready = 1'b1;
    clear_log();
    push(8'h12, 8'h34, 3'd0, p);
    push(8'h0F, 8'hA0, 3'd5, p);
    push(8'hFF, 8'h0F, 3'd6, p);
    push(8'hFF, 8'h02, 3'd0, p);
    wait_results(4, 100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 4", got_s.size()); end
    for (int i = 0; i < 4 && i < got_s.size(); i++) begin
      n_cmp++;
      if (got_s[i] !== exp_s[i] || got_op[i] !== exp_op[i] || got_flag[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got s=%h op=%h f=%b want %h %h %b",
                 i, got_s[i], got_op[i], got_flag[i], exp_s[i], exp_op[i], exp_f[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (got_cyc[i] - got_cyc[i-1] !== 4) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_full_fifo();
    logic [7:0] ca[6]  = '{8'hAA, 8'h11, 8'h55, 8'h80, 8'hF0, 8'hFF};
    logic [7:0] cb[6]  = '{8'h0F, 8'h22, 8'hFF, 8'h01, 8'h0F, 8'hFF};
    logic [2:0] co[6]  = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd7, 3'd4};
    logic [7:0] es[5]  = '{8'h0A, 8'h33, 8'hAA, 8'h81, 8'h00};
    int p;
    bit ok;
    res_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 5; i++) push(ca[i], cb[i], co[i], p);
    cmd_valid = 1'b1;
    cmd_a = ca[5];
    cmd_b = cb[5];
    cmd_op = co[5];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (res_valid !== 1'b1 || res_s !== 8'h0A || res_op !== 3'd4 || busy !== 1'b1 || dbg_state !== ST_HOLD) begin
        n_fail++;
        $display("FAIL full_hold: got v=%b s=%h op=%h busy=%b st=%0d want 1 0a 4 1 2",
                 res_valid, res_s, res_op, busy, dbg_state);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_results(5, 100, ok);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (got_s.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d results want 5", got_s.size()); end
    for (int i = 0; i < 5 && i < got_s.size(); i++) begin
      n_cmp++;
      if (got_s[i] !== es[i] || got_op[i] !== co[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: got s=%h op=%h want %h %h", i, got_s[i], got_op[i], es[i], co[i]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_simul_push_pop();
    int p;
    int k;
    bit ok;
    res_ready = 1'b0;
    clear_log();
    push(8'h03, 8'h05, 3'd0, p);
    push(8'h09, 8'h04, 3'd1, p);
    k = 0;
    while (res_valid !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL spp_first_valid: got 0 want 1"); end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 8'h3C;
    cmd_b = 8'hC3;
    cmd_op = 3'd5;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL spp_ready: got %b want 1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (dut.r_count !== 3'd1) begin n_fail++; $display("FAIL spp_count: got %0d want 1", dut.r_count); end
    n_cmp++;
    if (ula_a !== 8'h09 || ula_b !== 8'h04 || ula_op !== 3'd1 || dbg_state !== ST_WAIT) begin
      n_fail++;
      $display("FAIL spp_issue: got a=%h b=%h op=%h st=%0d want 09 04 1 1", ula_a, ula_b, ula_op, dbg_state);
    end
    wait_results(3, 60, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL spp_timeout: got %0d results want 3", got_s.size());
    end else begin
      n_cmp++;
      if (got_s[0] !== 8'h08 || got_s[1] !== 8'h05 || got_s[2] !== 8'hFF) begin
        n_fail++;
        $display("FAIL spp_order: got %h %h %h want 08 05 ff", got_s[0], got_s[1], got_s[2]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    int p;
    int n0;
    res_ready = 1'b1;
    clear_log();
    push(8'h77, 8'h11, 3'd6, p);
    push(8'h01, 8'h02, 3'd0, p);
    n_cmp++;
    if (dbg_state !== ST_WAIT || ula_a !== 8'h77) begin
      n_fail++; $display("FAIL rmw_in_wait: got st=%0d a=%h want 1 77", dbg_state, ula_a);
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    n_cmp++;
    if ({ula_a, ula_b, ula_op} !== 19'd0 || dbg_state !== ST_IDLE || busy !== 1'b0 || dut.r_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rmw_cleared: got a=%h b=%h op=%h st=%0d busy=%b cnt=%0d want all 0",
               ula_a, ula_b, ula_op, dbg_state, busy, dut.r_count);
    end
    n0 = valid_hi_cycles;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (valid_hi_cycles != n0 || got_s.size() != 0) begin
      n_fail++;
      $display("FAIL rmw_no_result: got %0d valid cycles, %0d results want 0 0", valid_hi_cycles - n0, got_s.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_back_to_back();
    test_full_fifo();
    test_simul_push_pop();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required finish before 200us");
    $fatal(1);
  end

endmodule
